// File: rtl/mux_bus_arbiter.sv
//-----------------------------------------------------------------------------
// mux_bus_arbiter
//
// Two-requester arbiter and sequencer for the shared 2:1 datapath
// multiplexer. One requester is granted at a time. The multiplexer select
// comes from a registered grant. The granted requester's word is captured
// into a registered output stage that uses valid/ready backpressure.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN - when both requests are high in IDLE, grant the
//                        requester that did not win last. If the macro is
//                        undefined, requester 0 wins every tie.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   req0/lock0/data0      requester 0 request, burst lock and data (MUX In1)
//   ack0                  requester 0 transfer accepted this cycle (comb.)
//   req1/lock1/data1      requester 1 request, burst lock and data (MUX In2)
//   ack1                  requester 1 transfer accepted this cycle (comb.)
//   sel                   registered MUX select (0 = req 0, 1 = req 1)
//   out_data/out_valid    captured word and its valid flag
//   out_ready             consumer accepts out_data when high with out_valid
//   busy                  arbiter is not IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; arbitrate among active requests
// GNT0  | requester 0 owns the MUX; transfers while the output stage is free
// GNT1  | requester 1 owns the MUX; transfers while the output stage is free
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module mux_bus_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             lock0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic             lock1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             free;
    logic             xfer;
    logic             tie_to1;
    logic [WIDTH-1:0] mux_data;

    assign free     = !out_valid || out_ready;
    assign ack0     = (state == GNT0) && req0 && free;
    assign ack1     = (state == GNT1) && req1 && free;
    assign xfer     = ack0 || ack1;
    assign busy     = (state != IDLE);
    assign mux_data = sel ? data1 : data0;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_to1 = !last_grant;
`else
    // The pointer is still maintained in this build but never steers a tie.
    assign tie_to1 = 1'b0 & last_grant;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = tie_to1 ? GNT1 : GNT0;
                end else if (req0) begin
                    state_nxt = GNT0;
                end else if (req1) begin
                    state_nxt = GNT1;
                end
            end
            // Dropping the request releases the grant even when locked.
            // Backpressure with req high holds the grant.
            GNT0: begin
                if (!req0) begin
                    state_nxt = IDLE;
                end else if (ack0 && !lock0) begin
                    state_nxt = IDLE;
                end
            end
            GNT1: begin
                if (!req1) begin
                    state_nxt = IDLE;
                end else if (ack1 && !lock1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            // sel and last_grant change only when a grant is entered from IDLE.
            if (state == IDLE && state_nxt == GNT0) begin
                sel        <= 1'b0;
                last_grant <= 1'b0;
            end else if (state == IDLE && state_nxt == GNT1) begin
                sel        <= 1'b1;
                last_grant <= 1'b1;
            end
        end
    end

    // A transfer on the same edge as a consume keeps valid high with new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data  <= mux_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
`timescale 1ns/1ps

module tb_mux_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, lock0, ack0;
    logic       req1, lock1, ack1;
    logic [7:0] data0, data1;
    logic       sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int n_chk;
    int n_pass;

    mux_bus_arbiter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .lock0     (lock0),
        .data0     (data0),
        .ack0      (ack0),
        .req1      (req1),
        .lock1     (lock1),
        .data1     (data1),
        .ack1      (ack1),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected contention order: three transfers.
    logic [7:0] exp_word [3];
    logic       exp_sel  [3];

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n     = 1'b0;
        req0      = 1'b0;
        lock0     = 1'b0;
        data0     = 8'h00;
        req1      = 1'b0;
        lock1     = 1'b0;
        data1     = 8'h00;
        out_ready = 1'b0;

`ifdef ARB_ROUND_ROBIN_EN
        // After the single req0 grant, last_grant=0, so requester 1 wins first.
        exp_word[0] = 8'h22; exp_sel[0] = 1'b1;
        exp_word[1] = 8'h11; exp_sel[1] = 1'b0;
        exp_word[2] = 8'h22; exp_sel[2] = 1'b1;
`else
        exp_word[0] = 8'h11; exp_sel[0] = 1'b0;
        exp_word[1] = 8'h11; exp_sel[1] = 1'b0;
        exp_word[2] = 8'h11; exp_sel[2] = 1'b0;
`endif

        // Reset state
        #3;
        chk("rst_sel", sel, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_busy", busy, 0);
        #9 rst_n = 1'b1;

        // Single request
        tick();
        req0 = 1'b1; data0 = 8'h3C; out_ready = 1'b1;
        #1;
        chk("single_ack0_idle", ack0, 0);
        tick();
        chk("single_sel", sel, 0);
        chk("single_busy", busy, 1);
        chk("single_ack0", ack0, 1);
        tick();
        chk("single_data", out_data, 8'h3C);
        chk("single_valid", out_valid, 1);
        chk("single_idle", busy, 0);
        req0 = 1'b0;
        tick();
        chk("single_consumed", out_valid, 0);

        // Contention
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("cont_sel_%0d", i), sel, exp_sel[i]);
            chk($sformatf("cont_ack0_%0d", i), ack0, !exp_sel[i]);
            chk($sformatf("cont_ack1_%0d", i), ack1, exp_sel[i]);
            tick();
            chk($sformatf("cont_data_%0d", i), out_data, exp_word[i]);
            chk($sformatf("cont_valid_%0d", i), out_valid, 1);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("cont_drained", out_valid, 0);

        // Burst lock on requester 1
        req1 = 1'b1; lock1 = 1'b1; data1 = 8'hA0;
        tick();
        chk("burst_sel", sel, 1);
        req0 = 1'b1; data0 = 8'h5A;
        #1;
        chk("burst_ack1_a0", ack1, 1);
        chk("burst_ack0_a0", ack0, 0);
        tick();
        chk("burst_data_a0", out_data, 8'hA0);
        data1 = 8'hA1;
        #1;
        chk("burst_ack1_a1", ack1, 1);
        chk("burst_ack0_a1", ack0, 0);
        tick();
        chk("burst_data_a1", out_data, 8'hA1);
        chk("burst_valid_a1", out_valid, 1);
        data1 = 8'hA2;
        #1;
        chk("burst_ack1_a2", ack1, 1);
        tick();
        chk("burst_data_a2", out_data, 8'hA2);
        chk("burst_held", busy, 1);
        req1 = 1'b0; lock1 = 1'b0;
        #1;
        chk("burst_ack1_drop", ack1, 0);
        tick();
        chk("burst_release", busy, 0);
        tick();
        chk("burst_req0_sel", sel, 0);
        chk("burst_req0_ack", ack0, 1);
        tick();
        chk("burst_req0_data", out_data, 8'h5A);
        req0 = 1'b0;

        // Backpressure: 0x5A is still unconsumed
        out_ready = 1'b0; req0 = 1'b1; data0 = 8'h55;
        tick();
        chk("bp_busy", busy, 1);
        chk("bp_ack0", ack0, 0);
        chk("bp_data_held", out_data, 8'h5A);
        tick();
        chk("bp_hold_busy", busy, 1);
        chk("bp_hold_ack0", ack0, 0);
        chk("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_ack0_ready", ack0, 1);
        tick();
        chk("bp_data_new", out_data, 8'h55);
        chk("bp_valid_kept", out_valid, 1);
        chk("bp_idle", busy, 0);
        req0 = 1'b0;

        // Asynchronous reset while in GNT1 with out_valid=1
        out_ready = 1'b0; req1 = 1'b1; data1 = 8'h77;
        tick();
        chk("rst_pre_sel", sel, 1);
        chk("rst_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_ack1", ack1, 0);
        chk("arst_busy", busy, 0);
        req0 = 1'b1; out_ready = 1'b1;
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_sel", sel, 0);
        chk("post_rst_ack0", ack0, 1);
        chk("post_rst_ack1", ack1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_bus_arbiter.md
# mux_bus_arbiter

Two-requester arbiter and sequencer for the shared 2:1 8-bit datapath multiplexer in the multi-cycle microcontroller. It grants one requester at a time and drives the multiplexer select from a registered grant state. It captures the granted requester's data into a registered output stage with valid/ready backpressure. Optional burst lock keeps a grant across back-to-back transfers.

## Interface
- `WIDTH`, 8, data width of both requester inputs and the output register.

- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0` in 1: requester 0 has valid data on `data0`.
- `lock0` in 1: requester 0 keeps the grant after a transfer.
- `data0` in WIDTH: requester 0 data, routed to MUX `In1`.
- `ack0` out 1: transfer accepted from requester 0 this cycle (combinational).
- `req1`, `lock1`, `data1`, `ack1`: same as above for requester 1; `data1` is routed to MUX `In2`.
- `sel` out 1: MUX select, registered; 0 selects requester 0, 1 selects requester 1.
- `out_data` out WIDTH: captured data.
- `out_valid` out 1: `out_data` holds an unconsumed word.
- `out_ready` in 1: consumer accepts `out_data` when high with `out_valid`.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, GNT0, GNT1.
- Internal `last_grant` pointer, 1 bit.
- Reset values: state IDLE, `sel`=0, `last_grant`=1, `out_data`=0, `out_valid`=0, `ack0`=`ack1`=0, `busy`=0.
- IDLE transitions:
  - neither request: stay in IDLE.
  - only `reqN` high: go to GNTN.
  - both high: winner per Configuration.
  - On entry to GNTN: `sel`<=N, `last_grant`<=N.
  - `sel` holds its value while in IDLE.
- Output stage free: `free = !out_valid || out_ready`.
- Acknowledge: `ackN = (state==GNTN) && reqN && free`. A transfer occurs on the edge where `reqN && ackN`.
- On a transfer:
  - `out_data`<=`dataN` (same value the MUX presents, since `sel`==N).
  - `out_valid`<=1.
- In GNTN, in priority order:
  1. `reqN` low: go to IDLE. This applies regardless of `lockN`.
  2. Transfer with `lockN` high: stay in GNTN.
  3. Transfer with `lockN` low: go to IDLE.
  4. `reqN` high but not `free`: stay in GNTN. The grant is held through backpressure and `ackN`=0.
- `out_valid` behaviour:
  - Clears when `out_valid && out_ready` and no transfer on the same edge.
  - A simultaneous consume and transfer leaves `out_valid`=1 with the new data.
- The non-granted requester's `ack` is always 0. No data is lost or duplicated.

## Timing
- Grant latency: `req` first sampled high in IDLE at edge k. `sel` and the GNT state are valid after edge k. `ack` can rise in the cycle following edge k. `out_valid` is high after edge k+1.
- Unlocked throughput: one transfer per 2 cycles per requester, due to the mandatory IDLE re-arbitration cycle.
- Locked throughput: one transfer per cycle while `free`.
- `ackN` is combinational from `reqN`, `out_valid`, `out_ready` and the state. Requesters must not make `reqN` depend combinationally on `ackN`.
- Asynchronous reset mid-transfer:
  - Immediately forces all reset values and discards any held `out_data`.
  - The first grant after release follows the tie rule with `last_grant`=1.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: when both requests are high in IDLE, grant the requester != `last_grant`.
  - Consequence: the first contested grant after reset goes to requester 0, and grants alternate thereafter.
- Undefined: fixed priority; requester 0 always wins ties in IDLE.
  - `last_grant` still updates but is unused.
  - Lock and backpressure behaviour are identical in both builds.

## Test plan
- Single request, round-robin: reset, then `req0`=1, `data0`=0x3C, `out_ready`=1.
  - `sel`=0 after 1 edge, `ack0`=1 in the next cycle, `out_data`=0x3C and `out_valid`=1 after 2 edges.
  - State returns to IDLE.
- Contention, round-robin: `req0` and `req1` held high, `data0`=0x11, `data1`=0x22, `out_ready`=1.
  - Outputs alternate 0x11, 0x22, 0x11, …, one word per 2 cycles.
  - Fixed-priority build: only 0x11 is accepted while `req0` stays high.
- Burst lock: `lock1`=1 with `req1` presenting 0xA0, 0xA1, 0xA2 on consecutive cycles.
  - Three consecutive `ack1` cycles, outputs 0xA0, 0xA1, 0xA2 back-to-back.
  - `req0` stays un-acked and is granted after `req1` drops.
- Backpressure: `out_valid`=1, `out_ready`=0, `req0` high with 0x55.
  - `ack0`=0 and state holds GNT0.
  - When `out_ready`=1: simultaneous consume and capture, `out_data`=0x55, `out_valid` stays 1.
- Reset mid-operation: assert `rst_n`=0 asynchronously while in GNT1 with `out_valid`=1.
  - All outputs take reset values before the next clock edge.
  - After release, both requests high gives `sel`=0 first.
